sillyfunction_lut: RTL and testbench

- Parametrised, registered successor to the 3-input sillyfunction: an N-input programmable truth-table (LUT) evaluator with valid/ready streaming and a built-in exhaustive sweep mode.
- The reset-default table reproduces sillyfunction: y = ~b & ~c | a & ~b, i.e. minterms 0, 4 and 5 with a as the MSB.
- Sits between stimulus sources (test harness or upstream logic) and consumers that need a registered boolean function of a small input vector.

---
 rtl/sillyfunction_pkg.sv | 18 +
 rtl/lut_cfg_shift.sv | 57 +++++
 rtl/sillyfunction_lut.sv | 148 ++++++++++++++
 tb/tb_sillyfunction_lut.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sillyfunction_pkg.sv
// Shared definitions for the sillyfunction LUT evaluator.
//   state_e   : sweep controller states
//   SILLY_TT  : truth table of y = ~b & ~c | a & ~b (minterms 0, 4, 5; a is MSB)
//   tt_width  : number of truth-table entries for n inputs
package sillyfunction_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic [7:0] SILLY_TT = 8'b0011_0001;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lut_cfg_shift.sv
// Serial truth-table loader.
// Bits arrive MSB (entry TT_W-1) first and shift into a shadow register. The
// TT_W-th bit raises commit_o combinationally, with commit_tt_o carrying the
// complete new table (including that bit), so the owner can copy it on the same
// edge. cfg_done_o is the registered commit, one cycle later.
//   clk, rst_n   : clock, async active-low reset
//   cfg_valid_i  : one table bit this cycle
//   cfg_bit_i    : the table bit
//   commit_o     : new table completes on this edge
//   commit_tt_o  : full table to commit
//   cfg_done_o   : one-cycle pulse after the commit edge
module lut_cfg_shift #(
  parameter int N_IN = 3,
  parameter int TT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid_i,
  input  logic            cfg_bit_i,
  output logic            commit_o,
  output logic [TT_W-1:0] commit_tt_o,
  output logic            cfg_done_o
);

  logic [TT_W-1:0] shadow_q, shadow_d;
  logic [N_IN-1:0] cnt_q, cnt_d;
  logic            done_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (cfg_valid_i) begin
      shadow_d = {shadow_q[TT_W-2:0], cfg_bit_i};
      // TT_W is exactly 2^N_IN, so the counter wraps to 0 on the commit bit by itself.
      cnt_d    = cnt_q + N_IN'(1);
    end
  end

  assign commit_o    = cfg_valid_i && (cnt_q == N_IN'(TT_W - 1));
  assign commit_tt_o = shadow_d;
  assign cfg_done_o  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= commit_o;
    end
  end

endmodule

// File: rtl/sillyfunction_lut.sv
// Registered N_IN-input programmable truth-table evaluator.
// Streams in_vec -> (out_y, out_vec) with one cycle of latency under valid/ready
// flow control, or sweeps every input vector in ascending order on sweep_start
// and reports how many of them produced y=1.
//   clk, rst_n                     : clock, async active-low reset
//   cfg_valid, cfg_bit, cfg_done   : serial table load (MSB first), commit pulse
//   in_valid, in_vec, in_ready     : input vector stream
//   sweep_start, sweep_busy        : exhaustive sweep control/status
//   out_valid, out_ready           : output handshake
//   out_y, out_vec, out_last       : result, producing vector, last-of-sweep flag
//   sweep_ones                     : 1-count of the last completed sweep
module sillyfunction_lut
  import sillyfunction_pkg::*;
#(
  parameter int                          N_IN       = 3,
  parameter logic [tt_width(N_IN)-1:0]   DEFAULT_TT = SILLY_TT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_y,
  output logic [N_IN-1:0] out_vec,
  output logic            out_last,
  output logic [N_IN:0]   sweep_ones
);

  localparam int            TT_W     = tt_width(N_IN);
  localparam logic [N_IN:0] LAST_CNT = (N_IN + 1)'(TT_W - 1);

  state_e            state_q;
  logic [N_IN:0]     cnt_q;
  logic [N_IN:0]     ones_acc_q;
  logic [N_IN:0]     sweep_ones_q;
  logic [TT_W-1:0]   table_q;
  logic              out_valid_q;
  logic              out_y_q;
  logic [N_IN-1:0]   out_vec_q;
  logic              out_last_q;

  logic              cfg_commit;
  logic [TT_W-1:0]   cfg_tt;

  logic              advance;
  logic              cap_stream;
  logic              cap_sweep;
  logic              capture;
  logic [N_IN-1:0]   cap_vec;
  logic              cap_y;
  logic              cap_last;
  logic [N_IN:0]     cap_inc;

  lut_cfg_shift #(
    .N_IN (N_IN),
    .TT_W (TT_W)
  ) u_cfg (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_bit_i   (cfg_bit),
    .commit_o    (cfg_commit),
    .commit_tt_o (cfg_tt),
    .cfg_done_o  (cfg_done)
  );

  // The output register may load whenever it is empty or being drained.
  assign advance    = !out_valid_q || out_ready;
  // sweep_start wins over a same-cycle stream vector, which stays unconsumed.
  assign in_ready   = (state_q == IDLE) && !sweep_start && advance;
  assign cap_stream = in_valid && in_ready;
  assign cap_sweep  = (state_q == SWEEP) && advance;
  assign capture    = cap_stream || cap_sweep;

  always_comb begin
    cap_vec = in_vec;
    if (state_q == SWEEP) cap_vec = cnt_q[N_IN-1:0];
  end

  // Captures read the pre-commit table, so a vector taken on the commit edge
  // still sees the old function.
  assign cap_y    = table_q[cap_vec];
  assign cap_last = cap_sweep && (cnt_q == LAST_CNT);
  assign cap_inc  = (N_IN + 1)'(cap_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ones_acc_q   <= '0;
      sweep_ones_q <= '0;
      // NOTE: the truth table is a plain register bank, not a RAM, so it takes a reset value.
      table_q      <= DEFAULT_TT;
      out_valid_q  <= 1'b0;
      out_y_q      <= 1'b0;
      out_vec_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      if (cfg_commit) table_q <= cfg_tt;

      // Without a capture the result fields hold; only out_valid clears on acceptance.
      if (capture) begin
        out_valid_q <= 1'b1;
        out_y_q     <= cap_y;
        out_vec_q   <= cap_vec;
        out_last_q  <= cap_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (sweep_start) begin
            state_q    <= SWEEP;
            cnt_q      <= '0;
            ones_acc_q <= '0;
          end
        end
        SWEEP: begin
          if (advance) begin
            cnt_q      <= cnt_q + (N_IN + 1)'(1);
            ones_acc_q <= ones_acc_q + cap_inc;
            if (cap_last) begin
              state_q      <= IDLE;
              sweep_ones_q <= ones_acc_q + cap_inc;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sweep_busy = (state_q == SWEEP);
  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_vec    = out_vec_q;
  assign out_last   = out_last_q;
  assign sweep_ones = sweep_ones_q;

endmodule

// File: tb/tb_sillyfunction_lut.sv
module tb_sillyfunction_lut;
  import sillyfunction_pkg::*;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_bit = 1'b0;
  logic         cfg_done;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_vec = '0;
  logic         in_ready;
  logic         sweep_start = 1'b0;
  logic         sweep_busy;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_y;
  logic [N-1:0] out_vec;
  logic         out_last;
  logic [N:0]   sweep_ones;

  sillyfunction_lut #(.N_IN(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_done    (cfg_done),
    .in_valid    (in_valid),
    .in_vec      (in_vec),
    .in_ready    (in_ready),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_vec     (out_vec),
    .out_last    (out_last),
    .sweep_ones  (sweep_ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         y;
    logic [N-1:0] vec;
    logic         last;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         pop_cnt = 0;
  int         last_cnt = 0;
  logic [7:0] tt_m = SILLY_TT;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] v, input logic last);
    exp_t e;
    e.y    = tt_m[v];
    e.vec  = v;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 8; i++) push_exp(N'(i), i == 7);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_last(input int target, input string tag);
    int n = 0;
    while (last_cnt < target && n < 100) begin
      step();
      n++;
    end
    check(tag, 32'(last_cnt >= target), 1);
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while (pop_cnt < target && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(pop_cnt >= target), 1);
  endtask

  task automatic load_table(input logic [7:0] val);
    for (int b = 0; b < 8; b++) begin
      cfg_valid = 1'b1;
      cfg_bit   = val[7-b];
      step();
      if (b < 7) check("cfg_done_early", cfg_done, 0);
    end
    cfg_valid = 1'b0;
    tt_m      = val;
    check("cfg_done_pulse", cfg_done, 1);
    step();
    check("cfg_done_clear", cfg_done, 0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  logic         held = 1'b0;
  logic [N-1:0] h_vec;
  logic         h_y;
  logic         h_last;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_vec", out_vec, h_vec);
        check("hold_y", out_y, h_y);
        check("hold_last", out_last, h_last);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_vec", out_vec, e.vec);
          check("out_y", out_y, e.y);
          check("out_last", out_last, e.last);
          pop_cnt++;
          if (out_last) last_cnt++;
        end
      end
      held   = out_valid && !out_ready;
      h_vec  = out_vec;
      h_y    = out_y;
      h_last = out_last;
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_vec", out_vec, 0);
    check("rst_out_last", out_last, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_sweep_busy", sweep_busy, 0);
    check("rst_sweep_ones", sweep_ones, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Stream vectors 0..7 against the default table
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1;
      in_vec   = N'(v);
      #1;
      check("stream_ready", in_ready, 1);
      push_exp(N'(v), 1'b0);
      step();
      check("stream_latency", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    check("valid_drop", out_valid, 0);

    // Sweep with out_ready held high
    sweep_start = 1'b1;
    push_sweep();
    step();
    sweep_start = 1'b0;
    #1;
    check("sweep_busy_on", sweep_busy, 1);
    check("sweep_in_ready", in_ready, 0);
    wait_last(1, "sweep1_done");
    check("sweep1_busy_off", sweep_busy, 0);
    check("sweep1_ones", sweep_ones, 3);

    // Sweep under backpressure pattern 1,0,0,1
    sweep_start = 1'b1;
    push_sweep();
    step();
    sweep_start = 1'b0;
    for (int c = 0; c < 100 && last_cnt < 2; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      step();
    end
    check("sweep2_done", 32'(last_cnt >= 2), 1);
    out_ready = 1'b1;
    step();
    check("sweep2_ones", sweep_ones, 3);

    // Load all-ones; vector 2 captured on the commit edge sees the old table
    for (int b = 0; b < 8; b++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      if (b == 7) begin
        in_valid = 1'b1;
        in_vec   = 3'd2;
        #1;
        check("commit_in_ready", in_ready, 1);
        push_exp(3'd2, 1'b0);
      end
      step();
      if (b < 7) check("cfg_done_early", cfg_done, 0);
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    tt_m      = 8'hFF;
    check("cfg_done_pulse", cfg_done, 1);
    in_valid = 1'b1;
    in_vec   = 3'd2;
    push_exp(3'd2, 1'b0);
    step();
    in_valid = 1'b0;
    check("cfg_done_clear", cfg_done, 0);
    sweep_start = 1'b1;
    push_sweep();
    step();
    sweep_start = 1'b0;
    wait_last(3, "sweep3_done");
    check("sweep3_ones", sweep_ones, 8);

    // Reset mid-sweep and mid-load
    begin
      int base;
      base        = pop_cnt;
      sweep_start = 1'b1;
      cfg_valid   = 1'b1;
      cfg_bit     = 1'b0;
      push_sweep();
      step();
      sweep_start = 1'b0;
      step();
      step();
      cfg_valid = 1'b0;
      wait_pops(base + 4, "reset_wait");
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_y", out_y, 0);
    check("mid_rst_out_vec", out_vec, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_busy", sweep_busy, 0);
    check("mid_rst_ones", sweep_ones, 0);
    check("mid_rst_cfg_done", cfg_done, 0);
    sb.delete();
    tt_m = SILLY_TT;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("no_last_after_abort", last_cnt, 3);

    // Default table restored: vec 3 -> 0, vec 5 -> 1
    in_valid = 1'b1;
    in_vec   = 3'd3;
    push_exp(3'd3, 1'b0);
    step();
    in_vec = 3'd5;
    push_exp(3'd5, 1'b0);
    step();
    in_valid = 1'b0;

    // Fresh load after the aborted partial shift
    load_table(8'b1010_0110);
    sweep_start = 1'b1;
    push_sweep();
    step();
    sweep_start = 1'b0;
    wait_last(4, "sweep4_done");
    check("sweep4_ones", sweep_ones, 4);

    // sweep_start and in_valid together: the streamed vector is not consumed
    in_valid    = 1'b1;
    in_vec      = 3'd5;
    sweep_start = 1'b1;
    #1;
    check("collide_in_ready", in_ready, 0);
    push_sweep();
    step();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    check("collide_busy", sweep_busy, 1);
    wait_last(5, "sweep5_done");
    check("sweep5_ones", sweep_ones, 4);

    step();
    step();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
